// File: rtl/video_timing_gen_if.sv
// Pixel-rate video bus between the timing generator and its consumers.
// The master side is the generator: it takes pixel data and control, drives timing.
interface video_timing_gen_if #(
    parameter int RGB_W = 24
);
    logic             ce_pix;
    logic [3:0]       crop_left;
    logic [8:0]       irq_line;
    logic [RGB_W-1:0] rgb_in;
    logic [RGB_W-1:0] rgb_out;
    logic             hb;
    logic             vb;
    logic             hs;
    logic             vs;
    logic             de;
    logic [8:0]       hcnt;
    logic [8:0]       vcnt;
    logic             line_irq;
    logic [7:0]       frame_cnt;

    modport master (
        input  ce_pix, crop_left, irq_line, rgb_in,
        output rgb_out, hb, vb, hs, vs, de, hcnt, vcnt, line_irq, frame_cnt
    );

    modport slave (
        output ce_pix, crop_left, irq_line, rgb_in,
        input  rgb_out, hb, vb, hs, vs, de, hcnt, vcnt, line_irq, frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, registered blank/sync/enable flags,
// blank-gated pixel path, per-line interrupt and completed-frame counter.
module video_timing_gen #(
    parameter int H_TOTAL      = 318,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 283,
    parameter int H_SYNC_END   = 303,
    parameter int V_TOTAL      = 256,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 251,
    parameter int V_SYNC_END   = 254,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int RGB_W        = 24
) (
    input  logic               clk_sys,
    input  logic               reset,
    video_timing_gen_if.master vid
);

    // Counters never exceed 511, but sync ends may equal 512, so compare in 10 bits.
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_SYNC_START);
    localparam logic [9:0] HS_FIN  = 10'(H_SYNC_END);
    localparam logic [9:0] VS_BEG  = 10'(V_SYNC_START);
    localparam logic [9:0] VS_FIN  = 10'(V_SYNC_END);

    generate
        if (!(H_ACTIVE <= H_SYNC_START && H_SYNC_START < H_SYNC_END &&
              H_SYNC_END <= H_TOTAL && H_TOTAL <= 512)) begin : g_bad_h
            $error("video_timing_gen: illegal horizontal timing parameters");
        end
        if (!(V_ACTIVE <= V_SYNC_START && V_SYNC_START < V_SYNC_END &&
              V_SYNC_END <= V_TOTAL && V_TOTAL <= 512)) begin : g_bad_v
            $error("video_timing_gen: illegal vertical timing parameters");
        end
    endgenerate

    logic [8:0]       hcnt_q, hcnt_d;
    logic [8:0]       vcnt_q, vcnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             hb_q, hb_d;
    logic             vb_q, vb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic             line_irq_q, line_irq_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic [9:0]       hpos;
    logic [9:0]       vpos;
    logic             hb_now;
    logic             vb_now;
    logic             de_now;

    // Flags for the position currently held in the counters; captured on the next ce.
    always_comb begin
        hpos   = {1'b0, hcnt_q};
        vpos   = {1'b0, vcnt_q};
        hb_now = (hcnt_q < {5'b0, vid.crop_left}) || (hpos >= H_ACT);
        vb_now = (vpos >= V_ACT);
        de_now = ~hb_now & ~vb_now;
    end

    always_comb begin
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        hb_d        = hb_q;
        vb_d        = vb_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        de_d        = de_q;
        line_irq_d  = line_irq_q;
        rgb_d       = rgb_q;
        if (vid.ce_pix) begin
            if (hpos == H_LAST) begin
                hcnt_d = '0;
                if (vpos == V_LAST) begin
                    vcnt_d      = '0;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    vcnt_d = vcnt_q + 9'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 9'd1;
            end
            hb_d       = hb_now;
            vb_d       = vb_now;
            de_d       = de_now;
            hs_d       = ((hpos >= HS_BEG) && (hpos < HS_FIN)) ? HS_POL : ~HS_POL;
            vs_d       = ((vpos >= VS_BEG) && (vpos < VS_FIN)) ? VS_POL : ~VS_POL;
            line_irq_d = (hcnt_q == 9'd0) && (vcnt_q == vid.irq_line);
            rgb_d      = de_now ? vid.rgb_in : '0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
            hb_q        <= 1'b1;
            vb_q        <= 1'b1;
            hs_q        <= ~HS_POL;
            vs_q        <= ~VS_POL;
            de_q        <= 1'b0;
            line_irq_q  <= 1'b0;
            rgb_q       <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
            hb_q        <= hb_d;
            vb_q        <= vb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            line_irq_q  <= line_irq_d;
            rgb_q       <= rgb_d;
        end
    end

    assign vid.hcnt      = hcnt_q;
    assign vid.vcnt      = vcnt_q;
    assign vid.frame_cnt = frame_cnt_q;
    assign vid.hb        = hb_q;
    assign vid.vb        = vb_q;
    assign vid.hs        = hs_q;
    assign vid.vs        = vs_q;
    assign vid.de        = de_q;
    assign vid.line_irq  = line_irq_q;
    assign vid.rgb_out   = rgb_q;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_TOTAL, default 318, pixels per line (counts 0..H_TOTAL-1).
REQ-002 Parameter H_ACTIVE, default 256, active pixels per line (0..H_ACTIVE-1 before crop).
REQ-003 Parameters H_SYNC_START / H_SYNC_END, default 283 / 303, hsync asserted for hcnt in [start, end).
REQ-004 Parameter V_TOTAL, default 256, lines per frame (counts 0..V_TOTAL-1).
REQ-005 Parameter V_ACTIVE, default 240, active lines (0..V_ACTIVE-1).
REQ-006 Parameters V_SYNC_START / V_SYNC_END, default 251 / 254, vsync asserted for vcnt in [start, end).
REQ-007 Parameters HS_POL / VS_POL, default 0 / 0, asserted sync level (0 = active-low).
REQ-008 Parameter RGB_W, default 24, pixel bus width.
REQ-009 clk_sys  in  1  sole clock; all state on rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 ce_pix  in  1  pixel clock enable; state advances only when high.
REQ-012 crop_left  in  4  pixels blanked at line start (0 = none); generalises the column-bug mask.
REQ-013 irq_line  in  9  line number for line_irq.
REQ-014 rgb_in  in  RGB_W  pixel data for current counter position.
REQ-015 rgb_out  out  RGB_W  blank-gated, registered pixel data.
REQ-016 hb, vb, hs, vs, de  out  1 each  registered hblank, vblank, hsync, vsync, display enable.
REQ-017 hcnt  out  9, vcnt  out  9  current counter position (unregistered view of counters).
REQ-018 line_irq  out  1  one-ce pulse at start of line irq_line.
REQ-019 frame_cnt  out  8  completed-frame counter.

Function
REQ-020 On ce_pix: hcnt increments; at hcnt==H_TOTAL-1 hcnt wraps to 0 and vcnt increments; at vcnt==V_TOTAL-1 with hcnt wrap, vcnt wraps to 0 and frame_cnt increments (wraps 255->0).
REQ-021 ce_pix low: all registers hold, including line_irq (a pending pulse lasts exactly one ce_pix-high cycle).
REQ-022 Outputs hb/vb/hs/vs/de/rgb_out are registered on ce_pix from the counter value before that edge; latency 1 ce relative to hcnt/vcnt, all mutually aligned.
REQ-023 hb = 1 when hcnt < crop_left or hcnt >= H_ACTIVE.
REQ-024 vb = 1 when vcnt >= V_ACTIVE.
REQ-025 hs = HS_POL when H_SYNC_START <= hcnt < H_SYNC_END, else ~HS_POL; vs likewise with vcnt and VS_POL.
REQ-026 de = ~hb & ~vb; rgb_out = de ? rgb_in : 0.
REQ-027 line_irq registers 1 when hcnt==0 and vcnt==irq_line, else 0; irq_line >= V_TOTAL never fires.
REQ-028 crop_left >= H_ACTIVE blanks the whole line; crop_left change takes effect at the next ce, no glitch beyond that pixel.
REQ-029 Parameter legality: H_ACTIVE <= H_SYNC_START < H_SYNC_END <= H_TOTAL <= 512, same for V; illegal sets are a synthesis-time error.

Reset
REQ-030 While reset high: hcnt=0, vcnt=0, frame_cnt=0, hb=1, vb=1, de=0, hs=~HS_POL, vs=~VS_POL, rgb_out=0, line_irq=0.
REQ-031 Reset asserted mid-line takes effect immediately (asynchronous); first ce after release evaluates position (0,0).

Verification
REQ-032 Defaults, crop_left=0, ce_pix every 4th clk, rgb_in=0xFFFFFF -> 318 ce per line, de high for 256 ce per active line, 240 active lines, hs low 20 ce, vs low 3 lines, frame = 81408 ce.
REQ-033 crop_left=5 -> de low for hcnt 0..4, first nonzero rgb_out at hcnt 5 (+1 ce), 251 active pixels per line.
REQ-034 irq_line=100 -> single line_irq pulse per frame, one ce wide, aligned to (hcnt=0,vcnt=100)+1 ce; irq_line=300 -> no pulse.
REQ-035 ce_pix held low 50 clks mid-line -> all outputs and counters frozen, resume without skipped or repeated pixel.
REQ-036 Reset asserted at (hcnt=200,vcnt=120) -> outputs at reset values same cycle; after release, frame_cnt=0 and timing restarts at (0,0).
REQ-037 Run 256 frames -> frame_cnt wraps 255->0, no timing drift.
